dyn_reconf_ctrl: RTL and testbench

//  DRP master sitting directly upstream of dyn_reconf. Applies a host-loaded table of
//  {DADDR, MASK, DATA} entries to the PLL by read-modify-write over DRP. Holds the PLL in

---
 rtl/dyn_reconf_pkg.sv | 42 ++++
 rtl/dyn_reconf_tbl.sv | 27 ++
 rtl/dyn_reconf_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_dyn_reconf_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dyn_reconf_pkg.sv
// Shared types and constants for the DRP table controller.
// Entry layout, FSM encoding, error codes and the RMW merge rule.
package dyn_reconf_pkg;

    localparam int DRP_ADDR_W = 7;
    localparam int DRP_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RD,
        ST_RD_WAIT,
        ST_WR,
        ST_WR_WAIT,
        ST_RELEASE,
        ST_LOCK_WAIT
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_DRDY = 2'd1,
        ERR_LOCK = 2'd2
    } err_code_t;

    typedef struct packed {
        logic [DRP_ADDR_W-1:0] addr;
        logic [DRP_DATA_W-1:0] mask;
        logic [DRP_DATA_W-1:0] data;
    } tbl_entry_t;

    localparam int TBL_ENTRY_W = $bits(tbl_entry_t);

    // mask bit 1 keeps the current register bit, 0 takes the new one
    function automatic logic [DRP_DATA_W-1:0] rmw_merge(
        input logic [DRP_DATA_W-1:0] cur,
        input logic [DRP_DATA_W-1:0] mask,
        input logic [DRP_DATA_W-1:0] data
    );
        return (cur & mask) | (data & ~mask);
    endfunction

endpackage

// File: rtl/dyn_reconf_tbl.sv
// Host-loaded entry table: one synchronous write port, one async read port.
// Contents are deliberately not reset so a table survives RST_N.
module dyn_reconf_tbl
    import dyn_reconf_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
)(
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  tbl_entry_t       wr_entry,
    input  logic [IDX_W-1:0] rd_idx,
    output tbl_entry_t       rd_entry
);

    tbl_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_entry;
        end
    end

    assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/dyn_reconf_ctrl.sv
// DRP master: applies table entries to the PLL by read-modify-write,
// holding PLL reset throughout, then waits for LOCKED and reports DONE/ERR.
module dyn_reconf_ctrl
    import dyn_reconf_pkg::*;
#(
    parameter int TABLE_DEPTH  = 16,
    parameter int IDX_W        = 4,
    parameter int RST_HOLD     = 4,
    parameter int DRP_TIMEOUT  = 64,
    parameter int LOCK_TIMEOUT = 4096
)(
    input  logic                  DCLK,
    input  logic                  RST_N,
    input  logic                  CFG_WE,
    input  logic [IDX_W-1:0]      CFG_IDX,
    input  logic [DRP_ADDR_W-1:0] CFG_ADDR,
    input  logic [DRP_DATA_W-1:0] CFG_MASK,
    input  logic [DRP_DATA_W-1:0] CFG_DATA,
    input  logic                  START,
    input  logic [IDX_W:0]        START_COUNT,
    output logic [DRP_ADDR_W-1:0] DADDR,
    output logic                  DEN,
    output logic                  DWE,
    output logic [DRP_DATA_W-1:0] DI,
    input  logic [DRP_DATA_W-1:0] DO,
    input  logic                  DRDY,
    output logic                  PLL_RST,
    input  logic                  LOCKED,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR,
    output logic [1:0]            ERR_CODE
);

    localparam int TMR_W =
        $clog2(LOCK_TIMEOUT + DRP_TIMEOUT + RST_HOLD + 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(RST_HOLD - 1);
    localparam logic [TMR_W-1:0] DRP_LAST  = TMR_W'(DRP_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam logic [IDX_W:0]   CNT_MAX   = (IDX_W + 1)'(TABLE_DEPTH);
    localparam logic [IDX_W:0]   CNT_ONE   = (IDX_W + 1)'(1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    state_t                  state, state_n;
    logic [IDX_W-1:0]        idx, idx_n;
    logic [IDX_W:0]          count, count_n;
    logic [TMR_W-1:0]        tmr, tmr_n;
    logic                    seen_low, seen_low_n;
    logic [DRP_DATA_W-1:0]   wr_data, wr_data_n;
    logic                    pll_rst, pll_rst_n;
    logic                    done_q, done_n;
    logic                    err_q, err_n;
    err_code_t               err_code, err_code_n;

    tbl_entry_t              cfg_entry;
    tbl_entry_t              cur;
    logic                    tbl_we;
    logic [IDX_W:0]          start_cnt;
    logic                    drp_ack;
    logic                    last_entry;

    assign tbl_we    = CFG_WE && (state == ST_IDLE);
    assign cfg_entry = '{addr: CFG_ADDR, mask: CFG_MASK, data: CFG_DATA};

    dyn_reconf_tbl #(
        .DEPTH (TABLE_DEPTH),
        .IDX_W (IDX_W)
    ) u_tbl (
        .clk      (DCLK),
        .we       (tbl_we),
        .wr_idx   (CFG_IDX),
        .wr_entry (cfg_entry),
        .rd_idx   (idx),
        .rd_entry (cur)
    );

    assign start_cnt  = (START_COUNT > CNT_MAX) ? CNT_MAX : START_COUNT;
    // a low DRDY must be seen first so idle-high slaves do not ack early
    assign drp_ack    = seen_low && DRDY;
    assign last_entry = ({1'b0, idx} + CNT_ONE) >= count;

    always_ff @(posedge DCLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            idx      <= '0;
            count    <= '0;
            tmr      <= '0;
            seen_low <= 1'b0;
            wr_data  <= '0;
            pll_rst  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            count    <= count_n;
            tmr      <= tmr_n;
            seen_low <= seen_low_n;
            wr_data  <= wr_data_n;
            pll_rst  <= pll_rst_n;
            done_q   <= done_n;
            err_q    <= err_n;
            err_code <= err_code_n;
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        count_n    = count;
        tmr_n      = tmr + TMR_ONE;
        seen_low_n = seen_low || !DRDY;
        wr_data_n  = wr_data;
        pll_rst_n  = pll_rst;
        done_n     = 1'b0;
        err_n      = 1'b0;
        err_code_n = err_code;
        DADDR      = '0;
        DEN        = 1'b0;
        DWE        = 1'b0;
        DI         = '0;

        unique case (state)
            ST_IDLE: begin
                tmr_n = '0;
                if (START) begin
                    err_code_n = ERR_NONE;
                    if (start_cnt == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n   = ST_HOLD;
                        count_n   = start_cnt;
                        pll_rst_n = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (tmr == HOLD_LAST) begin
                    state_n = ST_RD;
                    idx_n   = '0;
                end
            end
            ST_RD: begin
                DADDR      = cur.addr;
                DEN        = 1'b1;
                state_n    = ST_RD_WAIT;
                tmr_n      = '0;
                seen_low_n = !DRDY;
            end
            ST_RD_WAIT: begin
                DADDR = cur.addr;
                if (drp_ack) begin
                    wr_data_n = rmw_merge(DO, cur.mask, cur.data);
                    state_n   = ST_WR;
                end else if (tmr == DRP_LAST) begin
                    state_n    = ST_IDLE;
                    err_n      = 1'b1;
                    err_code_n = ERR_DRDY;
                    pll_rst_n  = 1'b0;
                end
            end
            ST_WR: begin
                DADDR      = cur.addr;
                DEN        = 1'b1;
                DWE        = 1'b1;
                DI         = wr_data;
                state_n    = ST_WR_WAIT;
                tmr_n      = '0;
                seen_low_n = !DRDY;
            end
            ST_WR_WAIT: begin
                DADDR = cur.addr;
                DI    = wr_data;
                if (drp_ack) begin
                    if (last_entry) begin
                        state_n   = ST_RELEASE;
                        pll_rst_n = 1'b0;
                    end else begin
                        state_n = ST_RD;
                        idx_n   = idx + IDX_ONE;
                    end
                end else if (tmr == DRP_LAST) begin
                    state_n    = ST_IDLE;
                    err_n      = 1'b1;
                    err_code_n = ERR_DRDY;
                    pll_rst_n  = 1'b0;
                end
            end
            // one full cycle of PLL_RST low before LOCKED is trusted
            ST_RELEASE: begin
                state_n = ST_LOCK_WAIT;
                tmr_n   = '0;
            end
            ST_LOCK_WAIT: begin
                if (LOCKED) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end else if (tmr == LOCK_LAST) begin
                    state_n    = ST_IDLE;
                    err_n      = 1'b1;
                    err_code_n = ERR_LOCK;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign BUSY     = (state != ST_IDLE);
    assign PLL_RST  = pll_rst;
    assign DONE     = done_q;
    assign ERR      = err_q;
    assign ERR_CODE = err_code;

endmodule

// File: tb/tb_dyn_reconf_ctrl.sv
// Bench for dyn_reconf_ctrl: DRP slave + PLL lock models, entry-level RMW
// model checked on every DEN, plus directed sequences with literal expectations.
module tb_dyn_reconf_ctrl;

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] mask;
        logic [15:0] data;
    } ent_t;

    logic        DCLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        CFG_WE = 1'b0;
    logic [3:0]  CFG_IDX = '0;
    logic [6:0]  CFG_ADDR = '0;
    logic [15:0] CFG_MASK = '0;
    logic [15:0] CFG_DATA = '0;
    logic        START = 1'b0;
    logic [4:0]  START_COUNT = '0;
    logic [6:0]  DADDR;
    logic        DEN;
    logic        DWE;
    logic [15:0] DI;
    logic [15:0] DO = 16'hDEAD;
    logic        DRDY = 1'b0;
    logic        PLL_RST;
    logic        LOCKED = 1'b0;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [1:0]  ERR_CODE;

    int checks = 0;
    int errors = 0;

    dyn_reconf_ctrl dut (
        .DCLK        (DCLK),
        .RST_N       (RST_N),
        .CFG_WE      (CFG_WE),
        .CFG_IDX     (CFG_IDX),
        .CFG_ADDR    (CFG_ADDR),
        .CFG_MASK    (CFG_MASK),
        .CFG_DATA    (CFG_DATA),
        .START       (START),
        .START_COUNT (START_COUNT),
        .DADDR       (DADDR),
        .DEN         (DEN),
        .DWE         (DWE),
        .DI          (DI),
        .DO          (DO),
        .DRDY        (DRDY),
        .PLL_RST     (PLL_RST),
        .LOCKED      (LOCKED),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .ERR         (ERR),
        .ERR_CODE    (ERR_CODE)
    );

    always #5 DCLK = ~DCLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // DRP slave: register image, configurable latency and DRDY idle level
    logic [15:0] sregs [128];
    int          slave_lat = 1;
    logic        drdy_idle = 1'b0;
    bit          never = 0;
    bit          pend = 0;
    int          lat = 0;
    logic [15:0] rd_val = '0;

    always @(negedge DCLK) begin
        if (!RST_N) begin
            DRDY = drdy_idle;
            DO   = 16'hDEAD;
            pend = 0;
        end else begin
            DO = 16'hDEAD;
            if (!drdy_idle) DRDY = 1'b0;
            if (DEN) begin
                if (DWE) sregs[DADDR] = DI;
                else rd_val = sregs[DADDR];
                DRDY = 1'b0;
                pend = !never;
                lat  = slave_lat;
            end else if (pend) begin
                lat--;
                if (lat <= 0) begin
                    DRDY = 1'b1;
                    DO   = rd_val;
                    pend = 0;
                end
            end
        end
    end

    // PLL: unlocked while in reset, locks a few cycles after release
    bit lock_never = 0;
    int lcnt = 0;
    always @(negedge DCLK) begin
        if (!RST_N || PLL_RST) begin
            LOCKED = 1'b0;
            lcnt   = 0;
        end else if (lock_never) begin
            LOCKED = 1'b0;
        end else if (lcnt < 3) begin
            lcnt++;
        end else begin
            LOCKED = 1'b1;
        end
    end

    // model: queued entries, each expands to read then merged write
    ent_t        tbl [16];
    ent_t        exp_q [$];
    ent_t        cur_e;
    bit          exp_wr = 0;
    bit          prev_den = 0;
    logic [15:0] model_regs [128];
    logic [15:0] exp_di;

    always @(negedge DCLK) begin
        if (!RST_N) begin
            prev_den = 0;
        end else begin
            if (DWE) chk("dwe_needs_den", DEN, 1'b1);
            if (DEN) begin
                chk("den_spacing", prev_den, 1'b0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_den", 1'b1, 1'b0);
                end else begin
                    cur_e = exp_q[0];
                    chk("den_we", DWE, exp_wr);
                    chk("den_addr", DADDR, cur_e.addr);
                    if (exp_wr) begin
                        exp_di = (model_regs[cur_e.addr] & cur_e.mask) |
                                 (cur_e.data & ~cur_e.mask);
                        chk("wr_di", DI, exp_di);
                        model_regs[cur_e.addr] = exp_di;
                        void'(exp_q.pop_front());
                        exp_wr = 0;
                    end else begin
                        exp_wr = 1;
                    end
                end
            end
            prev_den = DEN;
        end
    end

    task automatic flush_model();
        exp_q.delete();
        exp_wr = 0;
    endtask

    task automatic write_entry(input int i, input logic [6:0] a,
                               input logic [15:0] m, input logic [15:0] d);
        CFG_WE   = 1'b1;
        CFG_IDX  = 4'(i);
        CFG_ADDR = a;
        CFG_MASK = m;
        CFG_DATA = d;
        tbl[i]   = '{addr: a, mask: m, data: d};
        @(negedge DCLK);
        CFG_WE = 1'b0;
    endtask

    task automatic start_seq(input int n, input bit plan);
        int m;
        m = (n > 16) ? 16 : n;
        if (plan) for (int i = 0; i < m; i++) exp_q.push_back(tbl[i]);
        START       = 1'b1;
        START_COUNT = 5'(n);
        @(negedge DCLK);
        START       = 1'b0;
        START_COUNT = '0;
    endtask

    int          st_den, st_dwe, st_rst_pre, st_den_at, st_fall_at, st_end_at;
    logic        st_done, st_err;
    logic [15:0] st_first_wr;

    task automatic run_until_end(input int budget);
        logic rst_prev;
        st_den = 0; st_dwe = 0; st_rst_pre = 0;
        st_den_at = -1; st_fall_at = -1; st_end_at = -1;
        st_done = 0; st_err = 0; st_first_wr = '0;
        rst_prev = PLL_RST;
        for (int c = 0; c < budget; c++) begin
            if (DEN) begin
                st_den++;
                if (st_den_at < 0) st_den_at = c;
            end
            if (DEN && DWE) begin
                if (st_dwe == 0) st_first_wr = DI;
                st_dwe++;
            end
            if (PLL_RST && st_den_at < 0) st_rst_pre++;
            if (!PLL_RST && rst_prev && st_fall_at < 0) st_fall_at = c;
            rst_prev = PLL_RST;
            if (DONE || ERR) begin
                st_done   = DONE;
                st_err    = ERR;
                st_end_at = c;
                break;
            end
            @(negedge DCLK);
        end
        chk("end_seen", st_end_at >= 0, 1'b1);
    endtask

    function automatic int divide_of(input logic [15:0] r1, input logic [15:0] r2);
        if (r2[6]) return 1;
        return int'(r1[11:6]) + int'(r1[5:0]);
    endfunction

    function automatic int duty_of(input logic [15:0] r1, input logic [15:0] r2);
        if (r2[6]) return 500;
        return int'(r1[11:6]) * 1000 / divide_of(r1, r2);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: no summary after 1 ms");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 128; i++) begin
            sregs[i]      = '0;
            model_regs[i] = '0;
        end

        // 1: reset
        repeat (3) @(negedge DCLK);
        chk("reset_outputs",
            {DADDR, DEN, DWE, DI, PLL_RST, BUSY, DONE, ERR, ERR_CODE}, 0);
        RST_N = 1'b1;
        @(negedge DCLK);
        chk("post_reset_busy_den_rst", {BUSY, DEN, PLL_RST}, 3'b000);

        // 2: single overwrite entry
        write_entry(0, 7'h08, 16'h0000, 16'h6183);
        start_seq(1, 1);
        run_until_end(500);
        chk("t2_done", st_done, 1'b1);
        chk("t2_rst_hold_ge4", st_rst_pre >= 4, 1'b1);
        chk("t2_den_count", st_den, 2);
        chk("t2_dwe_count", st_dwe, 1);
        chk("t2_di", st_first_wr, 16'h6183);
        chk("t2_rst_busy_at_done", {PLL_RST, BUSY}, 2'b00);
        chk("t2_divide", divide_of(sregs[8], sregs[9]), 9);
        chk("t2_duty", duty_of(sregs[8], sregs[9]), 666);
        @(negedge DCLK);
        chk("t2_done_pulse", DONE, 1'b0);

        // 3: keep-all entry then new entry, idle-high slow slave
        drdy_idle = 1'b1;
        slave_lat = 3;
        write_entry(0, 7'h08, 16'hFFFF, 16'h1234);
        write_entry(1, 7'h09, 16'h0000, 16'h0043);
        start_seq(2, 1);
        run_until_end(500);
        chk("t3_done", st_done, 1'b1);
        chk("t3_den_count", st_den, 4);
        chk("t3_di_keep", st_first_wr, 16'h6183);
        chk("t3_reg9", sregs[9], 16'h0043);
        chk("t3_divide", divide_of(sregs[8], sregs[9]), 1);

        // 4: DRDY never returns
        drdy_idle = 1'b0;
        slave_lat = 1;
        never     = 1;
        @(negedge DCLK);
        start_seq(1, 1);
        run_until_end(500);
        chk("t4_err", st_err, 1'b1);
        chk("t4_err_code", ERR_CODE, 2'd1);
        chk("t4_pll_rst", PLL_RST, 1'b0);
        chk("t4_no_dwe", st_dwe, 0);
        chk("t4_timeout_window",
            (st_end_at - st_den_at >= 64) && (st_end_at - st_den_at <= 66), 1'b1);
        @(negedge DCLK);
        chk("t4_code_held", {ERR, ERR_CODE}, 3'b001);
        never = 0;
        flush_model();

        // 5: lock timeout, START ignored while busy, zero count
        lock_never = 1;
        start_seq(1, 1);
        START       = 1'b1;
        START_COUNT = 5'd3;
        @(negedge DCLK);
        START       = 1'b0;
        START_COUNT = '0;
        run_until_end(6000);
        chk("t5_err", st_err, 1'b1);
        chk("t5_err_code", ERR_CODE, 2'd2);
        chk("t5_den_count", st_den, 2);
        chk("t5_lock_window",
            (st_end_at - st_fall_at >= 4096) && (st_end_at - st_fall_at <= 4098), 1'b1);
        lock_never = 0;
        flush_model();
        start_seq(0, 0);
        run_until_end(5);
        chk("t5_zero_done", {st_done, 32'(st_end_at)}, {1'b1, 32'd0});
        chk("t5_zero_no_den", st_den, 0);
        chk("t5_zero_code_cleared", ERR_CODE, 2'd0);
        chk("t5_zero_rst", PLL_RST, 1'b0);

        // 6: reset during WR_WAIT, then a clean rerun
        slave_lat = 5;
        write_entry(0, 7'h0A, 16'h00F0, 16'hABCD);
        start_seq(1, 1);
        for (int c = 0; c < 200; c++) begin
            if (DEN && DWE) break;
            @(negedge DCLK);
        end
        chk("t6_reached_write", DEN && DWE, 1'b1);
        @(negedge DCLK);
        RST_N = 1'b0;
        #1;
        chk("t6_abort_outputs",
            {DADDR, DEN, DWE, DI, PLL_RST, BUSY, DONE, ERR, ERR_CODE}, 0);
        flush_model();
        repeat (2) @(negedge DCLK);
        RST_N = 1'b1;
        @(negedge DCLK);
        start_seq(1, 1);
        run_until_end(500);
        chk("t6_rerun_done", st_done, 1'b1);
        chk("t6_rerun_den", st_den, 2);
        chk("t6_reg_a", sregs[10], 16'hAB0D);

        // 7: count above depth is clamped to the whole table
        slave_lat = 1;
        write_entry(1, 7'h09, 16'h0000, 16'h0043);
        for (int i = 2; i < 16; i++)
            write_entry(i, 7'(8'h10 + i), 16'hFF00, 16'(i * 257));
        start_seq(20, 1);
        run_until_end(2000);
        chk("t7_done", st_done, 1'b1);
        chk("t7_den_count", st_den, 32);
        chk("t7_reg_1f", sregs[7'h1F], 16'h000F);
        chk("t7_model_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
